progress_arbiter: RTL and testbench

PROGRESS_ARBITER -- requirements
Module: progress_arbiter

---
 rtl/progress_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_progress_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/progress_arbiter.sv
// progress_arbiter
//   Chooses which of three loaders (tape, disk, ioctl download) owns the
//   on-screen progress bar. The bar can only change once per video frame, on
//   the rising edge of vblank. Optionally, after the last loader finishes, the
//   bar stays on screen at 100% for HOLD_FRAMES frames.
//
// Build option:
//   PROGRESS_ARB_HOLD_EN  defined   -> HOLD state and hold counter present
//                         undefined -> SHOW returns straight to IDLE, HOLD_FRAMES ignored
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   vblank       vertical blank, clk domain
//   req_active   busy flag per requester (bit0 tape, bit1 disk, bit2 ioctl)
//   req_current  packed 3 x 25-bit progress counts, requester i at [25i+24:25i]
//   req_max      packed 3 x 25-bit totals, same packing
//   pb_enable    progress bar overlay enable
//   pb_current   progress bar current value
//   pb_max       progress bar maximum value
//   src_id       selected requester: 0 tape, 1 disk, 2 ioctl, 3 none
//   busy         high whenever the arbiter is not idle
module progress_arbiter #(
    parameter logic [7:0] HOLD_FRAMES = 8'd50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic [2:0]  req_active,
    input  logic [74:0] req_current,
    input  logic [74:0] req_max,
    output logic        pb_enable,
    output logic [24:0] pb_current,
    output logic [24:0] pb_max,
    output logic [1:0]  src_id,
    output logic        busy
);

    // Smallest displayed maximum; keeps max[24:7] non-zero so the bar's
    // per-pixel step never collapses to zero.
    localparam logic [24:0] MIN_MAX = 25'd128;
    localparam logic [1:0]  SRC_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic        vblank_prev_r;
    logic        pb_enable_r;
    logic [24:0] pb_current_r;
    logic [24:0] pb_max_r;
    logic [1:0]  src_id_r;
    logic        busy_r;

`ifdef PROGRESS_ARB_HOLD_EN
    logic [7:0]  hold_cnt_r;
`else
    // HOLD_FRAMES has no effect in this build.
    logic        unused_hold_s;
    assign unused_hold_s = ^HOLD_FRAMES;
`endif

    logic        tick_s;
    logic        any_req_s;
    logic [1:0]  winner_s;
    logic [24:0] sel_cur_s;
    logic [24:0] sel_max_s;
    logic [24:0] show_max_s;
    logic [24:0] show_cur_s;

    // Lowest-index active requester wins; 3 when nobody is active.
    function automatic logic [1:0] pick_winner(input logic [2:0] act);
        logic [1:0] w;
        if (act[0]) begin
            w = 2'd0;
        end else if (act[1]) begin
            w = 2'd1;
        end else if (act[2]) begin
            w = 2'd2;
        end else begin
            w = SRC_NONE;
        end
        return w;
    endfunction

    // Extract one 25-bit lane from a packed triple.
    function automatic logic [24:0] pick_lane(input logic [74:0] v, input logic [1:0] s);
        logic [24:0] lane;
        case (s)
            2'd0:    lane = v[24:0];
            2'd1:    lane = v[49:25];
            2'd2:    lane = v[74:50];
            default: lane = 25'd0;
        endcase
        return lane;
    endfunction

    assign tick_s    = vblank & ~vblank_prev_r;
    assign any_req_s = |req_active;
    assign winner_s  = pick_winner(req_active);
    assign sel_cur_s = pick_lane(req_current, winner_s);
    assign sel_max_s = pick_lane(req_max, winner_s);

    // Clamp the winner's values into a displayable range.
    always_comb begin
        show_max_s = sel_max_s;
        show_cur_s = sel_cur_s;
        if (sel_max_s < MIN_MAX) begin
            show_max_s = MIN_MAX;
        end else begin
            show_max_s = sel_max_s;
        end
        if (sel_cur_s > show_max_s) begin
            show_cur_s = show_max_s;
        end else begin
            show_cur_s = sel_cur_s;
        end
    end

    // Arbiter state machine with registered bar outputs; moves only on frame ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            vblank_prev_r <= 1'b0;
            pb_enable_r   <= 1'b0;
            pb_current_r  <= 25'd0;
            pb_max_r      <= MIN_MAX;
            src_id_r      <= SRC_NONE;
            busy_r        <= 1'b0;
`ifdef PROGRESS_ARB_HOLD_EN
            hold_cnt_r    <= 8'd0;
`endif
        end else begin
            vblank_prev_r <= vblank;
            if (tick_s) begin
                if (any_req_s) begin
                    // Any active requester (from any state) shows the current winner.
                    state_r      <= ST_SHOW;
                    pb_enable_r  <= 1'b1;
                    busy_r       <= 1'b1;
                    src_id_r     <= winner_s;
                    pb_max_r     <= show_max_s;
                    pb_current_r <= show_cur_s;
`ifdef PROGRESS_ARB_HOLD_EN
                    hold_cnt_r   <= 8'd0;
`endif
                end else begin
                    case (state_r)
                        ST_SHOW: begin
`ifdef PROGRESS_ARB_HOLD_EN
                            if (HOLD_FRAMES == 8'd0) begin
                                state_r      <= ST_IDLE;
                                pb_enable_r  <= 1'b0;
                                busy_r       <= 1'b0;
                                src_id_r     <= SRC_NONE;
                                pb_max_r     <= MIN_MAX;
                                pb_current_r <= 25'd0;
                            end else begin
                                // Freeze a full bar at the last shown maximum.
                                state_r      <= ST_HOLD;
                                hold_cnt_r   <= HOLD_FRAMES - 8'd1;
                                pb_current_r <= pb_max_r;
                            end
`else
                            state_r      <= ST_IDLE;
                            pb_enable_r  <= 1'b0;
                            busy_r       <= 1'b0;
                            src_id_r     <= SRC_NONE;
                            pb_max_r     <= MIN_MAX;
                            pb_current_r <= 25'd0;
`endif
                        end
`ifdef PROGRESS_ARB_HOLD_EN
                        ST_HOLD: begin
                            if (hold_cnt_r == 8'd0) begin
                                state_r      <= ST_IDLE;
                                pb_enable_r  <= 1'b0;
                                busy_r       <= 1'b0;
                                src_id_r     <= SRC_NONE;
                                pb_max_r     <= MIN_MAX;
                                pb_current_r <= 25'd0;
                            end else begin
                                hold_cnt_r   <= hold_cnt_r - 8'd1;
                            end
                        end
`endif
                        default: begin
                            state_r      <= ST_IDLE;
                            pb_enable_r  <= 1'b0;
                            busy_r       <= 1'b0;
                            src_id_r     <= SRC_NONE;
                            pb_max_r     <= MIN_MAX;
                            pb_current_r <= 25'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign pb_enable  = pb_enable_r;
    assign pb_current = pb_current_r;
    assign pb_max     = pb_max_r;
    assign src_id     = src_id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_progress_arbiter.sv
// tb_progress_arbiter
//   Directed vectors with hand-computed expectations for progress_arbiter.
//   Built with HOLD_FRAMES=3; the hold-specific vectors follow the
//   PROGRESS_ARB_HOLD_EN build option.
module tb_progress_arbiter;

    logic        clk;
    logic        reset;
    logic        vblank;
    logic [2:0]  req_active;
    logic [74:0] req_current;
    logic [74:0] req_max;
    logic        pb_enable;
    logic [24:0] pb_current;
    logic [24:0] pb_max;
    logic [1:0]  src_id;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    progress_arbiter #(.HOLD_FRAMES(8'd3)) dut (
        .clk         (clk),
        .reset       (reset),
        .vblank      (vblank),
        .req_active  (req_active),
        .req_current (req_current),
        .req_max     (req_max),
        .pb_enable   (pb_enable),
        .pb_current  (pb_current),
        .pb_max      (pb_max),
        .src_id      (src_id),
        .busy        (busy)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick: vblank high for exactly one rising edge; returns after the update edge.
    task automatic do_tick();
        @(negedge clk) vblank = 1'b1;
        @(negedge clk) vblank = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [24:0] cur, input logic [24:0] mx);
        req_current[25*i +: 25] = cur;
        req_max[25*i +: 25]     = mx;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".en"},  {31'd0, pb_enable}, 32'd0);
        check_val({tag, ".src"}, {30'd0, src_id},    32'd3);
        check_val({tag, ".max"}, {7'd0, pb_max},     32'd128);
        check_val({tag, ".cur"}, {7'd0, pb_current}, 32'd0);
        check_val({tag, ".busy"}, {31'd0, busy},     32'd0);
    endtask

    task automatic check_show(input string tag, input logic [1:0] src,
                              input logic [24:0] cur, input logic [24:0] mx);
        check_val({tag, ".en"},  {31'd0, pb_enable}, 32'd1);
        check_val({tag, ".src"}, {30'd0, src_id},    {30'd0, src});
        check_val({tag, ".cur"}, {7'd0, pb_current}, {7'd0, cur});
        check_val({tag, ".max"}, {7'd0, pb_max},     {7'd0, mx});
        check_val({tag, ".busy"}, {31'd0, busy},     32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        vblank      = 1'b0;
        req_active  = 3'b000;
        req_current = 75'd0;
        req_max     = 75'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Idle frames.
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check_idle("idle_tick");
        end

        // Single source: disk.
        set_lane(1, 25'd5000, 25'd100000);
        req_active = 3'b010;
        do_tick();
        check_show("disk", 2'd1, 25'd5000, 25'd100000);

        // Mid-frame change stays invisible until the next tick.
        set_lane(1, 25'd7000, 25'd100000);
        repeat (5) @(negedge clk);
        check_val("midframe.cur", {7'd0, pb_current}, 32'd5000);
        do_tick();
        check_val("nexttick.cur", {7'd0, pb_current}, 32'd7000);

        // Tape pulses active between ticks only.
        @(negedge clk) req_active = 3'b011;
        @(negedge clk) req_active = 3'b010;
        repeat (2) @(negedge clk);
        check_val("toggle_between.src", {30'd0, src_id}, 32'd1);
        do_tick();
        check_val("toggle.src", {30'd0, src_id}, 32'd1);

        // Preemption by tape, max clamped up to 128.
        set_lane(0, 25'd10, 25'd50);
        req_active = 3'b011;
        do_tick();
        check_show("preempt", 2'd0, 25'd10, 25'd128);

        // Long vblank: only its first edge counts.
        req_active = 3'b010;
        @(negedge clk) vblank = 1'b1;
        repeat (2) @(negedge clk);
        check_val("longvb1.src", {30'd0, src_id}, 32'd1);
        req_active = 3'b001;
        repeat (4) @(negedge clk);
        check_val("longvb2.src", {30'd0, src_id}, 32'd1);
        vblank = 1'b0;

        // Current above max clamps to max.
        req_active = 3'b010;
        set_lane(1, 25'd200000, 25'd100000);
        do_tick();
        check_show("clamp", 2'd1, 25'd100000, 25'd100000);

        // ioctl alone, small max.
        set_lane(2, 25'd300, 25'd60);
        req_active = 3'b100;
        do_tick();
        check_show("ioctl", 2'd2, 25'd128, 25'd128);

        // Back to disk before going inactive.
        set_lane(1, 25'd5000, 25'd100000);
        req_active = 3'b010;
        do_tick();
        check_show("disk2", 2'd1, 25'd5000, 25'd100000);

        req_active = 3'b000;
`ifdef PROGRESS_ARB_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check_val("hold.en",  {31'd0, pb_enable}, 32'd1);
            check_val("hold.cur", {7'd0, pb_current}, 32'd100000);
            check_val("hold.max", {7'd0, pb_max},     32'd100000);
            check_val("hold.busy", {31'd0, busy},     32'd1);
        end
        do_tick();
        check_idle("hold_end");

        // HOLD interrupted by a new request.
        req_active = 3'b010;
        do_tick();
        req_active = 3'b000;
        do_tick();
        check_val("hold2.cur", {7'd0, pb_current}, 32'd100000);
        req_active = 3'b010;
        do_tick();
        check_show("hold_resume", 2'd1, 25'd5000, 25'd100000);

        // Reset in HOLD.
        req_active = 3'b000;
        do_tick();
        check_val("prereset.en", {31'd0, pb_enable}, 32'd1);
`else
        do_tick();
        check_idle("show_end");
        req_active = 3'b010;
        do_tick();
        check_show("reshow", 2'd1, 25'd5000, 25'd100000);
`endif
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        check_idle("midreset");

        // vblank already high at reset release gives an immediate tick.
        @(negedge clk) begin
            vblank     = 1'b1;
            req_active = 3'b010;
        end
        @(negedge clk) reset = 1'b0;
        check_idle("reset_vb_held");
        @(posedge clk) #1;
        check_show("release_tick", 2'd1, 25'd5000, 25'd100000);
        @(negedge clk) vblank = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
